// File: rtl/timer_countdown_core.sv
// ============================================================================
// Module      : timer_countdown_core
// Description : Prescaled countdown timer with sticky expiry flag, optional
//               auto-reload and live count readback.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_countdown_core #(
  parameter int CNT_W = 32,
  parameter int PSC_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic [PSC_W-1:0] prescale,
  input  logic             auto_reload,
  input  logic             expired_clr,
  output logic             expired,
  output logic             expire_pulse,
  output logic             running,
  output logic [CNT_W-1:0] count_value
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic             expired_q, expired_d;
  logic             pulse_q, pulse_d;
  logic             start_q, stop_q;

  logic w_start_rise;
  logic w_stop_rise;
  logic w_tick;

  assign w_start_rise = start & ~start_q;
  assign w_stop_rise  = stop & ~stop_q;
  assign w_tick       = (psc_q == prescale);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    psc_d     = psc_q;
    expired_d = expired_q;
    pulse_d   = 1'b0;

    // Clear first so that an expiry later in this block overrides it.
    if (expired_clr) begin
      expired_d = 1'b0;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (w_start_rise && !w_stop_rise) begin
          state_d   = ST_RUN;
          count_d   = load_value;
          psc_d     = '0;
          expired_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (w_stop_rise) begin
          state_d = ST_IDLE;
        end else if (w_start_rise) begin
          count_d   = load_value;
          psc_d     = '0;
          expired_d = 1'b0;
        end else if (w_tick) begin
          psc_d = '0;
          if (count_q <= CNT_W'(1)) begin
            expired_d = 1'b1;
            pulse_d   = 1'b1;
            if (auto_reload) begin
              count_d = load_value;
            end else begin
              count_d = '0;
              state_d = ST_DONE;
            end
          end else begin
            count_d = count_q - CNT_W'(1);
          end
        end else begin
          psc_d = psc_q + PSC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      psc_q     <= '0;
      expired_q <= 1'b0;
      pulse_q   <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      psc_q     <= psc_d;
      expired_q <= expired_d;
      pulse_q   <= pulse_d;
      start_q   <= start;
      stop_q    <= stop;
    end
  end

  assign expired      = expired_q;
  assign expire_pulse = pulse_q;
  assign running      = (state_q == ST_RUN);
  assign count_value  = count_q;

endmodule

`default_nettype wire
